// File: rtl/ts_cc_pkg.sv
// Shared constants, AFC field decoding and FSM states for the TS continuity-counter monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ts_cc_pkg;
    localparam logic [7:0]  TS_SYNC       = 8'h47;
    localparam logic [12:0] NULL_PID      = 13'h1FFF;
    localparam int          WORDS_PER_PKT = 47;

    localparam logic [1:0] AFC_RSVD    = 2'b00;
    localparam logic [1:0] AFC_PAYLOAD = 2'b01;
    localparam logic [1:0] AFC_ADAPT   = 2'b10;
    localparam logic [1:0] AFC_BOTH    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_BODY,
        ST_COMMIT
    } ts_state_t;

    function automatic logic afc_has_payload(input logic [1:0] afc);
        return (afc == AFC_PAYLOAD) || (afc == AFC_BOTH);
    endfunction

    function automatic logic afc_has_adapt(input logic [1:0] afc);
        return (afc == AFC_ADAPT) || (afc == AFC_BOTH);
    endfunction
endpackage

// File: rtl/ts_cc_pid_match.sv
// Loadable PID table with lowest-index-first match of the captured header PID.
// Latency: hit/idx registered one cycle after pid; table writes visible the next cycle.
// Backpressure: none, evaluates every cycle.
module ts_cc_pid_match
    import ts_cc_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int IDX_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [IDX_W-1:0] cfg_idx,
    input  logic [12:0]      cfg_pid,
    input  logic             cfg_en,
    input  logic [12:0]      pid,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);
    logic [12:0]       tbl_pid [NUM_CH];
    logic [NUM_CH-1:0] tbl_en;
    logic              hit_c;
    logic [IDX_W-1:0]  idx_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl_en <= '0;
            for (int i = 0; i < NUM_CH; i++) tbl_pid[i] <= NULL_PID;
        end else if (cfg_wr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    tbl_pid[i] <= cfg_pid;
                    tbl_en[i]  <= cfg_en;
                end
            end
        end
    end

    // Scan downwards so the lowest matching slot is the one left standing.
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (tbl_en[i] && (tbl_pid[i] == pid)) begin
                hit_c = 1'b1;
                idx_c = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit <= 1'b0;
            idx <= '0;
        end else begin
            hit <= hit_c;
            idx <= idx_c;
        end
    end
endmodule

// File: rtl/ts_cc_monitor.sv
// Per-PID continuity-counter checker on the 47-word TS stream with sticky flags and counters.
// Latency: commit 1 cycle after word 46, err_vec/cnt/pulse 2 cycles, err_any and rd_cnt +1 more.
// Backpressure: none; observes the stream, back-to-back packets overlap commit with words 0-1.
module ts_cc_monitor
    import ts_cc_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       ts_din,
    input  logic              ts_din_en,
    input  logic              cfg_wr,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [12:0]       cfg_pid,
    input  logic              cfg_en,
    input  logic              clr,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [NUM_CH-1:0] err_vec,
    output logic              err_any,
    output logic              cc_err_pulse,
    output logic [CNT_W-1:0]  short_cnt
);
    localparam logic [5:0]       LAST_WORD = 6'(WORDS_PER_PKT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    ts_state_t        state, state_nxt;
    logic [5:0]       wc, wc_nxt;
    logic             word0, word1, abort;
    logic [12:0]      hdr_pid;
    logic [1:0]       hdr_afc;
    logic [3:0]       hdr_cc;
    logic             hdr_ok, disc;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;

    logic [NUM_CH-1:0] valid, dup;
    logic [3:0]        last_cc [NUM_CH];
    logic [CNT_W-1:0]  cnt [NUM_CH];

    logic             sel_valid, sel_dup;
    logic [3:0]       sel_last;
    logic [CNT_W-1:0] rd_sel;
    logic             commit, cc_err, dup_nxt;
    logic             unused_bits;

    assign unused_bits = ^{ts_din[22:21], ts_din[7:6]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            wc    <= '0;
        end else begin
            state <= state_nxt;
            wc    <= wc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wc_nxt    = wc;
        word0     = 1'b0;
        word1     = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE, ST_COMMIT: begin
                if (ts_din_en) begin
                    state_nxt = ST_HDR;
                    wc_nxt    = 6'd1;
                    word0     = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                    wc_nxt    = '0;
                end
            end
            ST_HDR, ST_BODY: begin
                if (!ts_din_en) begin
                    state_nxt = ST_IDLE;
                    wc_nxt    = '0;
                    abort     = 1'b1;
                end else if (wc == LAST_WORD) begin
                    state_nxt = ST_COMMIT;
                    wc_nxt    = '0;
                end else begin
                    state_nxt = ST_BODY;
                    wc_nxt    = wc + 6'd1;
                    word1     = (state == ST_HDR);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                wc_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_pid <= NULL_PID;
            hdr_afc <= AFC_RSVD;
            hdr_cc  <= '0;
            hdr_ok  <= 1'b0;
            disc    <= 1'b0;
        end else begin
            if (word0) begin
                hdr_pid <= ts_din[20:8];
                hdr_afc <= ts_din[5:4];
                hdr_cc  <= ts_din[3:0];
                hdr_ok  <= (ts_din[31:24] == TS_SYNC) && !ts_din[23] &&
                           (ts_din[5:4] != AFC_RSVD) && (ts_din[20:8] != NULL_PID);
                disc    <= 1'b0;
            end
            if (word1)
                disc <= afc_has_adapt(hdr_afc) && (ts_din[31:24] != 8'h00) && ts_din[23];
        end
    end

    ts_cc_pid_match #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_pid_match (
        .clk     (clk),
        .rst     (rst),
        .cfg_wr  (cfg_wr),
        .cfg_idx (cfg_idx),
        .cfg_pid (cfg_pid),
        .cfg_en  (cfg_en),
        .pid     (hdr_pid),
        .hit     (match_hit),
        .idx     (match_idx)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_dup   = 1'b0;
        sel_last  = '0;
        rd_sel    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (match_idx == IDX_W'(i)) begin
                sel_valid = valid[i];
                sel_dup   = dup[i];
                sel_last  = last_cc[i];
            end
            if (rd_idx == IDX_W'(i)) rd_sel = cnt[i];
        end
    end

    // A table write to the slot being committed wins, as does clr.
    assign commit = (state == ST_COMMIT) && hdr_ok && match_hit && !clr &&
                    !(cfg_wr && (cfg_idx == match_idx));

    always_comb begin
        cc_err  = 1'b0;
        dup_nxt = 1'b0;
        if (!sel_valid || disc) begin
            dup_nxt = 1'b0;
        end else if (!afc_has_payload(hdr_afc)) begin
            cc_err  = (hdr_cc != sel_last);
            dup_nxt = sel_dup && (hdr_cc == sel_last);
        end else if (hdr_cc == 4'(sel_last + 4'd1)) begin
            dup_nxt = 1'b0;
        end else if ((hdr_cc == sel_last) && !sel_dup) begin
            dup_nxt = 1'b1;
        end else begin
            cc_err = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid        <= '0;
            dup          <= '0;
            err_vec      <= '0;
            err_any      <= 1'b0;
            cc_err_pulse <= 1'b0;
            rd_cnt       <= '0;
            short_cnt    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                last_cc[i] <= '0;
                cnt[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (clr || (cfg_wr && (cfg_idx == IDX_W'(i)))) begin
                    valid[i]   <= 1'b0;
                    dup[i]     <= 1'b0;
                    err_vec[i] <= 1'b0;
                    cnt[i]     <= '0;
                end else if (commit && (match_idx == IDX_W'(i))) begin
                    valid[i]   <= 1'b1;
                    dup[i]     <= dup_nxt;
                    last_cc[i] <= hdr_cc;
                    if (cc_err) begin
                        err_vec[i] <= 1'b1;
                        if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
                    end
                end
            end
            cc_err_pulse <= commit && cc_err;
            err_any      <= |err_vec;
            rd_cnt       <= rd_sel;
            if (clr)
                short_cnt <= '0;
            else if (abort && (short_cnt != CNT_MAX))
                short_cnt <= short_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ts_cc_monitor.sv
// Directed plus randomized packet stream against a packet-level continuity model.
module tb_ts_cc_monitor;
    localparam int NCH  = 8;
    localparam int CMAX = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ts_din = '0;
    logic        ts_din_en = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [4:0]  cfg_idx = '0;
    logic [12:0] cfg_pid = '0;
    logic        cfg_en = 1'b0;
    logic        clr = 1'b0;
    logic [4:0]  rd_idx = '0;
    logic [7:0]  rd_cnt;
    logic [7:0]  err_vec;
    logic        err_any;
    logic        cc_err_pulse;
    logic [7:0]  short_cnt;

    ts_cc_monitor #(.NUM_CH(NCH), .CNT_W(8), .IDX_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .ts_din       (ts_din),
        .ts_din_en    (ts_din_en),
        .cfg_wr       (cfg_wr),
        .cfg_idx      (cfg_idx),
        .cfg_pid      (cfg_pid),
        .cfg_en       (cfg_en),
        .clr          (clr),
        .rd_idx       (rd_idx),
        .rd_cnt       (rd_cnt),
        .err_vec      (err_vec),
        .err_any      (err_any),
        .cc_err_pulse (cc_err_pulse),
        .short_cnt    (short_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int pulse_seen = 0;

    always @(negedge clk) if (cc_err_pulse === 1'b1) pulse_seen++;

    // Reference state, one entry per table slot, tracked per whole packet.
    logic [12:0] m_pid   [NCH];
    bit          m_en    [NCH];
    bit          m_valid [NCH];
    bit          m_dup   [NCH];
    bit          m_err   [NCH];
    int          m_last  [NCH];
    int          m_cnt   [NCH];
    int          m_short  = 0;
    int          m_pulses = 0;
    logic [12:0] pool [4] = '{13'h100, 13'h101, 13'h102, 13'h103};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_w0(input logic [12:0] pid, input logic [1:0] afc,
                                          input logic [3:0] cc);
        return {8'h47, 1'b0, 2'b00, pid, 2'b00, afc, cc};
    endfunction

    function automatic logic [31:0] mk_w1(input bit d);
        return d ? 32'h0180_0000 : 32'h0100_0000;
    endfunction

    function automatic int find_slot(input logic [12:0] pid);
        for (int i = 0; i < NCH; i++) if (m_en[i] && m_pid[i] == pid) return i;
        return -1;
    endfunction

    function automatic logic [7:0] m_errvec();
        logic [7:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = m_err[i];
        return v;
    endfunction

    task automatic model_clear_slot(input int i);
        m_valid[i] = 0; m_dup[i] = 0; m_err[i] = 0; m_cnt[i] = 0;
    endtask

    task automatic model_commit(input logic [31:0] w0, input logic [31:0] w1, output bit err);
        int  s;
        int  cc;
        bit  d;
        logic [1:0] afc;
        err = 0;
        afc = w0[5:4];
        cc  = int'(w0[3:0]);
        if (w0[31:24] != 8'h47 || w0[23] || afc == 2'b00 || w0[20:8] == 13'h1FFF) return;
        s = find_slot(w0[20:8]);
        if (s < 0) return;
        d = afc[1] && (w1[31:24] != 8'h00) && w1[23];
        if (!m_valid[s])                               m_dup[s] = 0;
        else if (d)                                    m_dup[s] = 0;
        else if (!afc[0]) begin
            if (cc != m_last[s]) err = 1;
        end
        else if (cc == (m_last[s] + 1) % 16)           m_dup[s] = 0;
        else if (cc == m_last[s] && !m_dup[s])         m_dup[s] = 1;
        else                                           err = 1;
        if (err) begin
            m_dup[s] = 0;
            m_err[s] = 1;
            if (m_cnt[s] < CMAX) m_cnt[s]++;
            m_pulses++;
        end
        m_valid[s] = 1;
        m_last[s]  = cc;
    endtask

    task automatic drive_word(input logic [31:0] w, input logic en);
        ts_din    = w;
        ts_din_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [31:0] w0, input logic [31:0] w1, input int nwords,
                            input int gap, output bit exp_err);
        exp_err = 0;
        for (int i = 0; i < nwords; i++)
            drive_word((i == 0) ? w0 : (i == 1) ? w1 : $urandom, 1'b1);
        if (nwords == 47) model_commit(w0, w1, exp_err);
        else if (m_short < CMAX) m_short++;
        for (int i = 0; i < gap; i++) drive_word($urandom, 1'b0);
    endtask

    task automatic do_cfg(input int idx, input logic [12:0] pid, input bit en);
        drive_word('0, 1'b0);
        drive_word('0, 1'b0);
        cfg_wr = 1'b1; cfg_idx = 5'(idx); cfg_pid = pid; cfg_en = en;
        drive_word('0, 1'b0);
        cfg_wr = 1'b0;
        if (idx < NCH) begin
            m_pid[idx] = pid;
            m_en[idx]  = en;
            model_clear_slot(idx);
        end
    endtask

    task automatic do_clr();
        drive_word('0, 1'b0);
        drive_word('0, 1'b0);
        clr = 1'b1;
        drive_word('0, 1'b0);
        clr = 1'b0;
        for (int i = 0; i < NCH; i++) model_clear_slot(i);
        m_short = 0;
    endtask

    task automatic check_all(input string tag);
        repeat (3) drive_word('0, 1'b0);
        chk({tag, ".err_vec"}, 32'(err_vec), 32'(m_errvec()));
        chk({tag, ".err_any"}, 32'(err_any), 32'(|m_errvec()));
        chk({tag, ".short_cnt"}, 32'(short_cnt), 32'(m_short));
        chk({tag, ".pulses"}, 32'(pulse_seen), 32'(m_pulses));
        for (int i = 0; i < NCH; i++) begin
            rd_idx = 5'(i);
            drive_word('0, 1'b0);
            chk({tag, ".rd_cnt"}, 32'(rd_cnt), 32'(m_cnt[i]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bit e;
        for (int i = 0; i < NCH; i++) begin
            m_pid[i] = 13'h1FFF; m_en[i] = 0; m_last[i] = 0;
            model_clear_slot(i);
        end

        // Reset values
        repeat (3) drive_word('0, 1'b0);
        chk("rst.err_vec", 32'(err_vec), 32'h0);
        chk("rst.err_any", 32'(err_any), 32'h0);
        chk("rst.pulse", 32'(cc_err_pulse), 32'h0);
        chk("rst.short_cnt", 32'(short_cnt), 32'h0);
        chk("rst.rd_cnt", 32'(rd_cnt), 32'h0);
        rst = 1'b0;
        drive_word('0, 1'b0);

        // Clean CC run 0..9 on slot 0
        do_cfg(0, 13'h200, 1);
        for (int c = 0; c < 10; c++) send_pkt(mk_w0(13'h200, 2'b01, 4'(c)), '0, 47, 0, e);
        check_all("clean");

        // Duplicate then repeated duplicate, with pulse timing
        do_clr();
        send_pkt(mk_w0(13'h200, 2'b01, 4'd3), '0, 47, 0, e);
        send_pkt(mk_w0(13'h200, 2'b01, 4'd4), '0, 47, 0, e);
        send_pkt(mk_w0(13'h200, 2'b01, 4'd4), '0, 47, 0, e);
        send_pkt(mk_w0(13'h200, 2'b01, 4'd4), '0, 47, 0, e);
        chk("dup.pulse_commit_cycle", 32'(cc_err_pulse), 32'h0);
        drive_word('0, 1'b0);
        chk("dup.pulse_2cyc", 32'(cc_err_pulse), 32'(e));
        drive_word('0, 1'b0);
        chk("dup.pulse_end", 32'(cc_err_pulse), 32'h0);
        check_all("dup");

        // Discontinuity indicator
        do_clr();
        send_pkt(mk_w0(13'h200, 2'b11, 4'd5), mk_w1(1'b0), 47, 0, e);
        send_pkt(mk_w0(13'h200, 2'b11, 4'd9), mk_w1(1'b1), 47, 0, e);
        check_all("disc1");
        do_clr();
        send_pkt(mk_w0(13'h200, 2'b11, 4'd5), mk_w1(1'b0), 47, 0, e);
        send_pkt(mk_w0(13'h200, 2'b11, 4'd9), mk_w1(1'b0), 47, 0, e);
        check_all("disc0");

        // Truncated packet leaves CC history untouched
        do_clr();
        send_pkt(mk_w0(13'h200, 2'b01, 4'd7), '0, 47, 0, e);
        send_pkt(mk_w0(13'h200, 2'b01, 4'd8), '0, 20, 1, e);
        chk("abort.short_cnt_1cyc", 32'(short_cnt), 32'(m_short));
        send_pkt(mk_w0(13'h200, 2'b01, 4'd8), '0, 47, 0, e);
        check_all("abort");

        // Slots 0 and 3 interleaved, error on slot 3 only
        do_clr();
        do_cfg(3, 13'h345, 1);
        send_pkt(mk_w0(13'h200, 2'b01, 4'd0), '0, 47, 0, e);
        send_pkt(mk_w0(13'h345, 2'b01, 4'd0), '0, 47, 0, e);
        send_pkt(mk_w0(13'h200, 2'b01, 4'd1), '0, 47, 0, e);
        send_pkt(mk_w0(13'h345, 2'b01, 4'd1), '0, 47, 0, e);
        send_pkt(mk_w0(13'h200, 2'b01, 4'd2), '0, 47, 0, e);
        send_pkt(mk_w0(13'h345, 2'b01, 4'd5), '0, 47, 0, e);
        drive_word('0, 1'b0);
        chk("two.err_vec", 32'(err_vec), 32'(m_errvec()));
        chk("two.err_any_lag", 32'(err_any), 32'h0);
        drive_word('0, 1'b0);
        chk("two.err_any", 32'(err_any), 32'h1);
        check_all("two");
        do_clr();
        check_all("clr");
        do_cfg(3, 13'h1FFF, 1);
        for (int c = 0; c < 4; c++) send_pkt(mk_w0(13'h1FFF, 2'b01, 4'(c * 5)), '0, 47, 0, e);
        check_all("nullpid");

        // Randomized traffic, table churn and clears
        for (int i = 0; i < NCH; i++) do_cfg(i, pool[$urandom_range(0, 3)], $urandom_range(0, 3) != 0);
        for (int p = 0; p < 160; p++) begin
            logic [12:0] pid;
            logic [1:0]  afc;
            logic [3:0]  cc;
            logic [31:0] w0, w1;
            int s, nw, gap;
            pid = pool[$urandom_range(0, 3)];
            if ($urandom_range(0, 15) == 0) pid = 13'($urandom);
            s = find_slot(pid);
            cc = (s >= 0 && m_valid[s]) ? 4'(m_last[s]) : 4'($urandom);
            case ($urandom_range(0, 5))
                0:       cc = cc;
                1, 2, 3: cc = cc + 4'd1;
                4:       cc = cc + 4'd2;
                default: cc = 4'($urandom);
            endcase
            afc = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) afc = 2'b00;
            w0 = mk_w0(pid, afc, cc);
            if ($urandom_range(0, 19) == 0) w0[31:24] = 8'h46;
            if ($urandom_range(0, 19) == 0) w0[23] = 1'b1;
            w1 = ($urandom_range(0, 2) == 0) ? mk_w1($urandom_range(0, 1) == 1) : $urandom;
            nw = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 46) : 47;
            gap = (nw < 47) ? $urandom_range(1, 3) : $urandom_range(0, 2);
            send_pkt(w0, w1, nw, gap, e);
            if (p % 12 == 11) begin
                if ($urandom_range(0, 3) == 0) do_clr();
                else do_cfg($urandom_range(0, 9), pool[$urandom_range(0, 3)], $urandom_range(0, 3) != 0);
            end
            if (p % 8 == 7) check_all("rand");
        end

        // Counter saturation
        do_clr();
        do_cfg(0, 13'h200, 1);
        send_pkt(mk_w0(13'h200, 2'b01, 4'd0), '0, 47, 0, e);
        for (int c = 1; c <= 300; c++) send_pkt(mk_w0(13'h200, 2'b01, 4'(c * 2)), '0, 47, 0, e);
        send_pkt(mk_w0(13'h200, 2'b01, 4'd0), '0, 10, 1, e);
        check_all("sat");

        // Asynchronous reset in the middle of a packet
        rd_idx = 5'd0;
        for (int i = 0; i < 10; i++) drive_word((i == 0) ? mk_w0(13'h200, 2'b01, 4'd1) : $urandom, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst.err_vec", 32'(err_vec), 32'h0);
        chk("arst.err_any", 32'(err_any), 32'h0);
        chk("arst.rd_cnt", 32'(rd_cnt), 32'h0);
        chk("arst.short_cnt", 32'(short_cnt), 32'h0);
        chk("arst.pulse", 32'(cc_err_pulse), 32'h0);
        for (int i = 0; i < NCH; i++) begin
            m_en[i] = 0; m_pid[i] = 13'h1FFF;
            model_clear_slot(i);
        end
        m_short = 0;
        drive_word('0, 1'b0);
        rst = 1'b0;
        send_pkt(mk_w0(13'h200, 2'b01, 4'd9), '0, 47, 0, e);
        send_pkt(mk_w0(13'h200, 2'b01, 4'd3), '0, 47, 0, e);
        check_all("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
